// File: rtl/branch_check.sv
// Branch prediction checker: queues IF predictions and resolves them against ID.
// Optional statistics counters are enabled by defining BRANCH_CHECK_STAT_EN.
module branch_check #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        pred_push,
  input  logic [31:0] pred_pc,
  input  logic [32:0] pred_pta,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_is_branch,
  input  logic [1:0]  id_br_type,
  input  logic        id_dir,
  input  logic [31:0] id_tar,
  output logic        queue_full,
  output logic        queue_empty,
  output logic [34:0] branch_info,
  output logic        branch_info_valid,
  output logic        pred_flag,
  output logic        flush,
  output logic [31:0] redirect_pc
`ifdef BRANCH_CHECK_STAT_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {NORMAL, FLUSH} state_t;

  state_t        state;
  logic [31:0]   pc_mem  [QUEUE_DEPTH];
  logic          dir_mem [QUEUE_DEPTH];
  logic [31:0]   tar_mem [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic        head_valid;
  logic [31:0] head_pc;
  logic        head_dir;
  logic [31:0] head_tar;
  logic        pop;
  logic        deq;
  logic        push;
  logic        mispredict;
  logic [31:0] redirect_calc;

  assign queue_full  = (count == CW'(QUEUE_DEPTH));
  assign queue_empty = (count == '0);

  // An empty queue behaves as a not-taken prediction with no PC to compare against.
  always_comb begin
    head_valid    = !queue_empty;
    head_pc       = pc_mem[rd_ptr];
    head_dir      = head_valid & dir_mem[rd_ptr];
    head_tar      = head_valid ? tar_mem[rd_ptr] : 32'd0;
    pop           = id_valid & !stall & (state == NORMAL);
    deq           = pop & head_valid;
    push          = pred_push & !stall & (state == NORMAL) & (!queue_full | deq);
    mispredict    = head_valid & (head_pc != id_pc);
    redirect_calc = id_pc + 32'd4;
    if (id_is_branch) begin
      if ((head_dir != id_dir) || (head_dir && id_dir && (head_tar != id_tar)))
        mispredict = 1'b1;
      redirect_calc = id_dir ? id_tar : id_pc + 32'd8;
    end else if (head_dir) begin
      mispredict = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= pred_pc;
      dir_mem[wr_ptr] <= pred_pta[32];
      tar_mem[wr_ptr] <= pred_pta[31:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= NORMAL;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
      branch_info       <= '0;
      branch_info_valid <= 1'b0;
      pred_flag         <= 1'b1;
      flush             <= 1'b0;
      redirect_pc       <= '0;
    end else if (!stall) begin
      case (state)
        NORMAL: begin
          branch_info_valid <= pop & id_is_branch;
          pred_flag         <= !(pop & mispredict);
          if (pop && id_is_branch)
            branch_info <= {id_dir, id_tar, id_br_type};
          if (pop && mispredict) begin
            state       <= FLUSH;
            flush       <= 1'b1;
            redirect_pc <= redirect_calc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
          end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (deq)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, deq})
              2'b10:   count <= count + CW'(1);
              2'b01:   count <= count - CW'(1);
              default: count <= count;
            endcase
          end
        end
        FLUSH: begin
          state             <= NORMAL;
          flush             <= 1'b0;
          branch_info_valid <= 1'b0;
          pred_flag         <= 1'b1;
          rd_ptr            <= '0;
          wr_ptr            <= '0;
          count             <= '0;
        end
        default: state <= NORMAL;
      endcase
    end
  end

`ifdef BRANCH_CHECK_STAT_EN
  // Saturating event counters; pops only happen in NORMAL and never under stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop && id_is_branch && (stat_branches != '1))
        stat_branches <= stat_branches + 32'd1;
      if (pop && mispredict && (stat_mispred != '1))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_check.sv
// Scoreboard testbench for branch_check: directed vectors, expectations queued per pop.
module tb_branch_check;

  logic        clk;
  logic        resetn;
  logic        stall;
  logic        pred_push;
  logic [31:0] pred_pc;
  logic [32:0] pred_pta;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_is_branch;
  logic [1:0]  id_br_type;
  logic        id_dir;
  logic [31:0] id_tar;
  logic        queue_full;
  logic        queue_empty;
  logic [34:0] branch_info;
  logic        branch_info_valid;
  logic        pred_flag;
  logic        flush;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        flag;
    logic        biv;
    logic [34:0] bi;
    logic        fl;
    logic [31:0] rpc;
    string       name;
  } exp_t;

  exp_t sb[$];

  branch_check #(.QUEUE_DEPTH(4)) dut (
    .clk(clk),
    .resetn(resetn),
    .stall(stall),
    .pred_push(pred_push),
    .pred_pc(pred_pc),
    .pred_pta(pred_pta),
    .id_valid(id_valid),
    .id_pc(id_pc),
    .id_is_branch(id_is_branch),
    .id_br_type(id_br_type),
    .id_dir(id_dir),
    .id_tar(id_tar),
    .queue_full(queue_full),
    .queue_empty(queue_empty),
    .branch_info(branch_info),
    .branch_info_valid(branch_info_valid),
    .pred_flag(pred_flag),
    .flush(flush),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectResp(input logic flag, input logic biv, input logic [34:0] bi,
                            input logic fl, input logic [31:0] rpc, input string name);
    exp_t e;
    e.flag = flag; e.biv = biv; e.bi = bi; e.fl = fl; e.rpc = rpc; e.name = name;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic push, input logic [31:0] ppc, input logic [32:0] pta,
                               input logic idv, input logic [31:0] ipc, input logic isbr,
                               input logic [1:0] bt, input logic dir, input logic [31:0] tar,
                               input logic st);
    pred_push = push; pred_pc = ppc; pred_pta = pta;
    id_valid = idv; id_pc = ipc; id_is_branch = isbr; id_br_type = bt;
    id_dir = dir; id_tar = tar; stall = st;
    @(posedge clk);
    #1;
    pred_push = 1'b0; id_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 33'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic pushOnly(input logic [31:0] ppc, input logic [32:0] pta);
    applyStimulus(1'b1, ppc, pta, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic popOnly(input logic [31:0] ipc, input logic isbr, input logic [1:0] bt,
                         input logic dir, input logic [31:0] tar);
    applyStimulus(1'b0, 32'h0, 33'h0, 1'b1, ipc, isbr, bt, dir, tar, 1'b0);
  endtask

  // Monitor: a response is a valid branch_info or the rising edge of flush.
  initial begin : monitor
    logic flush_d;
    exp_t e;
    flush_d = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (branch_info_valid || (flush && !flush_d)) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_response: got biv=%0b flush=%0b, expected no response",
                     branch_info_valid, flush);
          end else begin
            e = sb.pop_front();
            checkOutput({e.name, ".pred_flag"}, 64'(pred_flag), 64'(e.flag));
            checkOutput({e.name, ".biv"}, 64'(branch_info_valid), 64'(e.biv));
            checkOutput({e.name, ".flush"}, 64'(flush), 64'(e.fl));
            if (e.biv) checkOutput({e.name, ".branch_info"}, 64'(branch_info), 64'(e.bi));
            if (e.fl)  checkOutput({e.name, ".redirect_pc"}, 64'(redirect_pc), 64'(e.rpc));
          end
        end
        flush_d = flush;
      end else begin
        flush_d = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    resetn = 1'b0; stall = 1'b0; pred_push = 1'b0; pred_pc = '0; pred_pta = '0;
    id_valid = 1'b0; id_pc = '0; id_is_branch = 1'b0; id_br_type = '0; id_dir = 1'b0; id_tar = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.queue_full", 64'(queue_full), 64'd0);
    checkOutput("rst.queue_empty", 64'(queue_empty), 64'd1);
    checkOutput("rst.branch_info", 64'(branch_info), 64'd0);
    checkOutput("rst.biv", 64'(branch_info_valid), 64'd0);
    checkOutput("rst.pred_flag", 64'(pred_flag), 64'd1);
    checkOutput("rst.flush", 64'(flush), 64'd0);
    checkOutput("rst.redirect_pc", 64'(redirect_pc), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] correct taken branch");
    pushOnly(32'h100, {1'b1, 32'h200});
    checkOutput("push.queue_empty", 64'(queue_empty), 64'd0);
    expectResp(1'b1, 1'b1, {1'b1, 32'h200, 2'b01}, 1'b0, 32'h0, "predict_ok");
    popOnly(32'h100, 1'b1, 2'b01, 1'b1, 32'h200);
    idle();
    checkOutput("after_ok.biv", 64'(branch_info_valid), 64'd0);
    checkOutput("after_ok.pred_flag", 64'(pred_flag), 64'd1);

    $display("[TB] direction mispredict");
    pushOnly(32'h100, {1'b0, 32'h0});
    expectResp(1'b0, 1'b1, {1'b1, 32'h400, 2'b10}, 1'b1, 32'h400, "dir_mispred");
    popOnly(32'h100, 1'b1, 2'b10, 1'b1, 32'h400);
    checkOutput("dir_mispred.queue_empty", 64'(queue_empty), 64'd1);
    idle();
    checkOutput("dir_mispred.flush_end", 64'(flush), 64'd0);

    $display("[TB] full queue with push and pop together");
    pushOnly(32'h10, {1'b0, 32'h0});
    pushOnly(32'h14, {1'b0, 32'h0});
    pushOnly(32'h18, {1'b0, 32'h0});
    pushOnly(32'h1C, {1'b0, 32'h0});
    checkOutput("fill.queue_full", 64'(queue_full), 64'd1);
    applyStimulus(1'b1, 32'h20, {1'b0, 32'h0}, 1'b1, 32'h10, 1'b0, 2'b00, 1'b0, 32'h0, 1'b0);
    checkOutput("pushpop.queue_full", 64'(queue_full), 64'd1);
    popOnly(32'h14, 1'b0, 2'b00, 1'b0, 32'h0);
    popOnly(32'h18, 1'b0, 2'b00, 1'b0, 32'h0);
    popOnly(32'h1C, 1'b0, 2'b00, 1'b0, 32'h0);
    expectResp(1'b1, 1'b1, {1'b0, 32'h0, 2'b00}, 1'b0, 32'h0, "fifth_entry");
    popOnly(32'h20, 1'b1, 2'b00, 1'b0, 32'h0);
    checkOutput("drain.queue_empty", 64'(queue_empty), 64'd1);
    idle();

    $display("[TB] pc mismatch on non-branch");
    pushOnly(32'h500, {1'b0, 32'h0});
    expectResp(1'b0, 1'b0, 35'h0, 1'b1, 32'h508, "pc_mismatch");
    popOnly(32'h504, 1'b0, 2'b00, 1'b0, 32'h0);
    idle();

    $display("[TB] taken target mismatch");
    pushOnly(32'h600, {1'b1, 32'h700});
    expectResp(1'b0, 1'b1, {1'b1, 32'h704, 2'b11}, 1'b1, 32'h704, "target_mispred");
    popOnly(32'h600, 1'b1, 2'b11, 1'b1, 32'h704);
    idle();

    $display("[TB] predicted taken, not taken, pc wraps");
    pushOnly(32'hFFFF_FFFC, {1'b1, 32'h40});
    expectResp(1'b0, 1'b1, {1'b0, 32'h40, 2'b01}, 1'b1, 32'h4, "wrap_fallthrough");
    popOnly(32'hFFFF_FFFC, 1'b1, 2'b01, 1'b0, 32'h40);
    idle();

    $display("[TB] non-branch predicted taken");
    pushOnly(32'h300, {1'b1, 32'h380});
    expectResp(1'b0, 1'b0, 35'h0, 1'b1, 32'h304, "nonbranch_taken");
    popOnly(32'h300, 1'b0, 2'b00, 1'b0, 32'h0);
    checkOutput("nonbranch_taken.biv", 64'(branch_info_valid), 64'd0);
    idle();

    $display("[TB] stalled flush");
    pushOnly(32'h400, {1'b1, 32'h480});
    expectResp(1'b0, 1'b0, 35'h0, 1'b1, 32'h404, "stall_flush");
    popOnly(32'h400, 1'b0, 2'b00, 1'b0, 32'h0);
    checkOutput("stall_flush.start", 64'(flush), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h999, {1'b0, 32'h0}, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("stall_flush.held%0d", i), 64'(flush), 64'd1);
      checkOutput($sformatf("stall_flush.empty%0d", i), 64'(queue_empty), 64'd1);
    end
    pushOnly(32'h998, {1'b0, 32'h0});
    checkOutput("stall_flush.end", 64'(flush), 64'd0);
    checkOutput("stall_flush.no_push", 64'(queue_empty), 64'd1);
    idle();

    $display("[TB] reset during flush");
    pushOnly(32'h300, {1'b1, 32'h0});
    expectResp(1'b0, 1'b0, 35'h0, 1'b1, 32'h304, "reset_flush");
    popOnly(32'h300, 1'b0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst.flush", 64'(flush), 64'd0);
    checkOutput("async_rst.pred_flag", 64'(pred_flag), 64'd1);
    checkOutput("async_rst.queue_empty", 64'(queue_empty), 64'd1);
    checkOutput("async_rst.redirect_pc", 64'(redirect_pc), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput($sformatf("post_rst.flush%0d", i), 64'(flush), 64'd0);
    end

    repeat (2) idle();
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
